// File: rtl/frac_div_period_monitor.sv
// frac_div_period_monitor
// Watches the 1-cycle strobe of a fractional clock divider. After a start it
// locks onto the next strobe, then measures WIN_PULSES consecutive strobe
// intervals in clk cycles. It reports their sum, minimum and maximum, flags
// intervals outside [MIN_ALLOWED, MAX_ALLOWED], and aborts the run if no
// strobe arrives within TIMEOUT cycles.
module frac_div_period_monitor #(
    parameter int unsigned WIN_PULSES  = 10,
    parameter int unsigned MIN_ALLOWED = 7,
    parameter int unsigned MAX_ALLOWED = 8,
    parameter int unsigned TIMEOUT     = 32,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SUM_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] total_cycles,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic [CNT_W-1:0] n_intervals,
    output logic             range_err,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYNC    = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_MIN      = CNT_W'(MIN_ALLOWED);
    localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_ALLOWED);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(WIN_PULSES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_p_cnt;
    logic             r_busy;
    logic             r_done;
    logic [SUM_W-1:0] r_total;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_n;
    logic             r_range_err;
    logic             r_timeout_err;

    logic w_start_ok;
    logic w_counting;
    logic w_record;
    logic w_timeout;
    logic w_last;
    logic w_out_of_range;

    // A start is only honoured from IDLE; strobes before SYNC never count.
    assign w_start_ok     = (r_state == S_IDLE) && start;
    assign w_counting     = (r_state == S_SYNC) || (r_state == S_MEASURE);
    assign w_record       = (r_state == S_MEASURE) && pulse_in;
    // A strobe landing in the cycle the count hits TIMEOUT wins over the abort.
    assign w_timeout      = w_counting && !pulse_in && (r_p_cnt == C_TIMEOUT);
    assign w_last         = (r_n == C_LAST_IDX);
    assign w_out_of_range = (r_p_cnt < C_MIN) || (r_p_cnt > C_MAX);

    // Next-state decode for the run sequence IDLE -> SYNC -> MEASURE -> DONE.
    always_comb begin
        // NOTE: default assigned first so every path drives w_next_state; no latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_SYNC;
            end
            S_SYNC: begin
                if (pulse_in)       w_next_state = S_MEASURE;
                else if (w_timeout) w_next_state = S_DONE;
            end
            S_MEASURE: begin
                if (pulse_in && w_last) w_next_state = S_DONE;
                else if (w_timeout)     w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking updates so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == S_SYNC) || (w_next_state == S_MEASURE);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    // Cycles since SYNC entry or since the last strobe; saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_cnt <= '0;
        end else if (w_start_ok) begin
            r_p_cnt <= C_ONE;
        end else if (w_counting) begin
            if (pulse_in)                  r_p_cnt <= C_ONE;
            else if (r_p_cnt != C_CNT_MAX) r_p_cnt <= r_p_cnt + 1'b1;
        end
    end

    // Result accumulation: cleared on an accepted start, updated per interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total       <= '0;
            r_min         <= '0;
            r_max         <= '0;
            r_n           <= '0;
            r_range_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else if (w_start_ok) begin
            r_total       <= '0;
            r_min         <= '0;
            r_max         <= '0;
            r_n           <= '0;
            r_range_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_record) begin
                r_total <= r_total + SUM_W'(r_p_cnt);
                r_n     <= r_n + 1'b1;
                // First interval of the run seeds both extremes.
                if ((r_n == '0) || (r_p_cnt < r_min)) r_min <= r_p_cnt;
                if ((r_n == '0) || (r_p_cnt > r_max)) r_max <= r_p_cnt;
                if (w_out_of_range) r_range_err <= 1'b1;
            end
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign total_cycles = r_total;
    assign min_period   = r_min;
    assign max_period   = r_max;
    assign n_intervals  = r_n;
    assign range_err    = r_range_err;
    assign timeout_err  = r_timeout_err;

endmodule
